// File: rtl/cbus_mem_responder.sv
// CBus burst memory responder: FIXED/INCR/WRAP bursts over an internal 64-bit word array.
// Optional build macro CBUS_RESP_STALL_EN inserts one idle cycle between beats.
package cbus_pkg;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} cbus_size_e;
    typedef enum logic [1:0] {MBURST_FIXED, MBURST_INCR, MBURST_WRAP, MBURST_RSVD} cbus_burst_e;

    // len encodes beats-1
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        cbus_size_e  size;
        logic [3:0]  len;
        cbus_burst_e burst;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    localparam int AW = $clog2(MEM_WORDS);

`ifdef CBUS_RESP_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, addr_nxt, addr_step;
    logic [31:0] wbase_q;
    logic [7:0]  wmask_q;
    logic [7:0]  wsize_acc;
    cbus_size_e  size_q;
    cbus_burst_e burst_q;
    logic [3:0]  len_q;
    logic        wr_q;
    logic [3:0]  beat_q, beat_nxt;
    logic [3:0]  lat_q, lat_nxt;
    logic        gap_q, gap_nxt;
    logic [AW-1:0] cur_idx, widx_q, widx_nxt;
    logic [31:0] incr_addr;
    cbus_resp_t  resp_nxt;
    logic        accept;

    logic [63:0] mem [MEM_WORDS];

    assign accept  = (state == IDLE) && creq.valid;
    assign cur_idx = addr_q[3 +: AW];

    // WRAP window in bytes; burst length is expected to be a power of two for WRAP
    assign wsize_acc = ({4'd0, creq.len} + 8'd1) << creq.size;

    // Address sequencing; reserved burst type behaves as INCR
    always_comb begin
        incr_addr = addr_q + (32'd1 << size_q);
        addr_step = incr_addr;
        unique case (burst_q)
            MBURST_FIXED: addr_step = addr_q;
            MBURST_WRAP:  addr_step = ((incr_addr - wbase_q) > {24'd0, wmask_q}) ? wbase_q : incr_addr;
            default:      addr_step = incr_addr;
        endcase
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        lat_nxt   = lat_q;
        beat_nxt  = beat_q;
        gap_nxt   = gap_q;
        widx_nxt  = widx_q;
        resp_nxt  = '0;
        unique case (state)
            IDLE: begin
                if (creq.valid) begin
                    addr_nxt  = creq.addr;
                    lat_nxt   = 4'(LATENCY);
                    beat_nxt  = '0;
                    gap_nxt   = 1'b0;
                    state_nxt = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                lat_nxt = lat_q - 4'd1;
                if (lat_q <= 4'd1) state_nxt = BURST;
            end
            BURST: begin
                if (gap_q) begin
                    gap_nxt = 1'b0;
                end else begin
                    resp_nxt.ready = 1'b1;
                    resp_nxt.last  = (beat_q == len_q);
                    resp_nxt.data  = wr_q ? 64'd0 : mem[cur_idx];
                    widx_nxt       = cur_idx;
                    addr_nxt       = addr_step;
                    beat_nxt       = beat_q + 4'd1;
                    if (beat_q == len_q) state_nxt = DONE;
                    else                 gap_nxt   = STALL;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            addr_q <= '0;
            lat_q  <= '0;
            beat_q <= '0;
            gap_q  <= 1'b0;
            widx_q <= '0;
            cresp  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            lat_q  <= lat_nxt;
            beat_q <= beat_nxt;
            gap_q  <= gap_nxt;
            widx_q <= widx_nxt;
            cresp  <= resp_nxt;
        end
    end

    // Request attributes captured once at acceptance; master keeps them stable anyway
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            size_q  <= MSIZE1;
            burst_q <= MBURST_FIXED;
            len_q   <= '0;
            wr_q    <= 1'b0;
            wbase_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            size_q  <= creq.size;
            burst_q <= creq.burst;
            len_q   <= creq.len;
            wr_q    <= creq.is_write;
            wmask_q <= wsize_acc - 8'd1;
            wbase_q <= creq.addr & ~{24'd0, wsize_acc - 8'd1};
        end
    end

    // Write beat commits at the edge closing its ready cycle; reset clears ready so an
    // interrupted beat never lands
    always_ff @(posedge clk) begin
        if (cresp.ready && wr_q) begin
            for (int k = 0; k < 8; k++) begin
                if (creq.strobe[k]) mem[widx_q][8*k +: 8] <= creq.data[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: latency, burst types, strobes, back-to-back, reset abort.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam int LAT = 2;
`ifdef CBUS_RESP_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] rd [16];

    cbus_mem_responder #(.MEM_WORDS(1024), .LATENCY(LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ready pattern from first to last beat, one bit per cycle
    function automatic logic [31:0] exp_pat(input logic [3:0] ln);
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i <= int'(ln); i++) begin
            if (i > 0 && STALL) p = p << 1;
            p = (p << 1) | 32'd1;
        end
        return p;
    endfunction

    // One transaction from IDLE; abort_at >= 0 pulls reset during that beat
    task automatic xfer(input logic wr, input logic [31:0] a, input cbus_size_e sz,
                        input logic [3:0] ln, input cbus_burst_e bt, input int abort_at);
        int cyc, nb, first, lastc;
        logic [31:0] pat;
        bit aborted;
        @(negedge clk);
        creq.valid = 1'b1; creq.is_write = wr; creq.addr = a; creq.size = sz;
        creq.len = ln; creq.burst = bt; creq.data = '0; creq.strobe = '0;
        cyc = 0; nb = 0; first = -1; lastc = -1; pat = '0; aborted = 1'b0;
        while (lastc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (first >= 0) pat = {pat[30:0], cresp.ready};
            if (cresp.ready) begin
                if (first < 0) begin first = cyc; pat = 32'd1; end
                if (nb == abort_at) begin
                    resetn = 1'b0;
                    #1;
                    chk("abort_ctl", {62'd0, cresp.ready, cresp.last}, 64'd0);
                    chk("abort_data", cresp.data, 64'd0);
                    aborted = 1'b1;
                    lastc = cyc;
                end else begin
                    if (wr) begin
                        creq.data = wd[nb]; creq.strobe = ws[nb];
                        chk("wr_resp_data", cresp.data, 64'd0);
                    end else begin
                        rd[nb] = cresp.data;
                    end
                    chk("last_pos", 64'(cresp.last), 64'(nb == int'(ln)));
                    if (cresp.last) lastc = cyc;
                    nb++;
                end
            end
        end
        creq.valid = 1'b0;
        if (lastc < 0) begin
            chk("timeout", 64'd0, 64'd1);
        end else if (aborted) begin
            @(negedge clk);
            resetn = 1'b1;
        end else begin
            chk("latency", 64'(first), 64'(LAT + 2));
            chk("beats", 64'(nb), 64'(int'(ln) + 1));
            chk("ready_pat", 64'(pat), 64'(exp_pat(ln)));
        end
    endtask

    initial begin
        int t [4];
        int nr, cyc;
        creq = '0;
        resetn = 1'b0;

        // Reset held with a request pending: outputs stay zero
        creq.valid = 1'b1; creq.addr = 32'h8000_0000; creq.size = MSIZE8;
        creq.len = MLEN1; creq.burst = MBURST_INCR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ctl", {62'd0, cresp.ready, cresp.last}, 64'd0);
            chk("rst_data", cresp.data, 64'd0);
        end
        resetn = 1'b1;
        cyc = 0;
        while (!cresp.ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rst_latency", 64'(cyc), 64'(LAT + 2));
        chk("rst_last", 64'(cresp.last), 64'd1);
        creq.valid = 1'b0;

        // INCR write 0x11..0x44 then read back
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(8'h11 * (i + 1)); ws[i] = 8'hFF; end
        xfer(1'b1, 32'h8000_0000, MSIZE8, MLEN4, MBURST_INCR, -1);
        xfer(1'b0, 32'h8000_0000, MSIZE8, MLEN4, MBURST_INCR, -1);
        chk("incr_rd0", rd[0], 64'h11);
        chk("incr_rd1", rd[1], 64'h22);
        chk("incr_rd2", rd[2], 64'h33);
        chk("incr_rd3", rd[3], 64'h44);

        // WRAP: 0x10, 0x18, wrap to 0x00, 0x08
        xfer(1'b0, 32'h8000_0010, MSIZE8, MLEN4, MBURST_WRAP, -1);
        chk("wrap_rd0", rd[0], 64'h33);
        chk("wrap_rd1", rd[1], 64'h44);
        chk("wrap_rd2", rd[2], 64'h11);
        chk("wrap_rd3", rd[3], 64'h22);

        // 4-byte steps: two beats per word
        xfer(1'b0, 32'h8000_0004, MSIZE4, MLEN4, MBURST_INCR, -1);
        chk("sz4_rd0", rd[0], 64'h11);
        chk("sz4_rd1", rd[1], 64'h22);
        chk("sz4_rd2", rd[2], 64'h22);
        chk("sz4_rd3", rd[3], 64'h33);

        // Strobe merge on low half
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        xfer(1'b1, 32'h8000_0040, MSIZE8, MLEN1, MBURST_INCR, -1);
        wd[0] = 64'd0; ws[0] = 8'h0F;
        xfer(1'b1, 32'h8000_0040, MSIZE8, MLEN1, MBURST_INCR, -1);
        xfer(1'b0, 32'h8000_0040, MSIZE8, MLEN1, MBURST_INCR, -1);
        chk("strobe_merge", rd[0], 64'hFFFF_FFFF_0000_0000);

        // FIXED write: second beat overwrites only byte 0 of the same word
        wd[0] = 64'h1234_5678_9ABC_DEF0; ws[0] = 8'hFF;
        wd[1] = 64'h0;                   ws[1] = 8'h01;
        xfer(1'b1, 32'h8000_0200, MSIZE8, MLEN2, MBURST_FIXED, -1);
        xfer(1'b0, 32'h8000_0200, MSIZE8, MLEN2, MBURST_FIXED, -1);
        chk("fixed_rd0", rd[0], 64'h1234_5678_9ABC_DE00);
        chk("fixed_rd1", rd[1], 64'h1234_5678_9ABC_DE00);

        // Back-to-back with valid held high across two 2-beat reads
        @(negedge clk);
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h8000_0000;
        creq.size = MSIZE8; creq.len = MLEN2; creq.burst = MBURST_INCR;
        nr = 0; cyc = 0;
        while (nr < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cresp.ready) begin
                t[nr] = cyc;
                if (nr == 2) chk("b2b_data", cresp.data, 64'h11);
                nr++;
            end
        end
        creq.valid = 1'b0;
        chk("b2b_count", 64'(nr), 64'd4);
        if (nr == 4) begin
            chk("b2b_first", 64'(t[0]), 64'(LAT + 2));
            chk("b2b_gap", 64'(t[2] - t[1]), 64'(LAT + 3));
            chk("b2b_beat", 64'(t[3] - t[2]), STALL ? 64'd2 : 64'd1);
        end
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cresp.ready) nr++;
        end
        chk("b2b_quiet", 64'(nr), 64'd0);

        // Reset during beat 2 of a 4-beat write: beats 0-1 land, 2-3 keep old data
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0A0_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
        xfer(1'b1, 32'h8000_0100, MSIZE8, MLEN4, MBURST_INCR, -1);
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hB0B0_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
        xfer(1'b1, 32'h8000_0100, MSIZE8, MLEN4, MBURST_INCR, 2);
        xfer(1'b0, 32'h8000_0100, MSIZE8, MLEN4, MBURST_INCR, -1);
        chk("abort_rd0", rd[0], 64'hB0B0_0000_0000_0000);
        chk("abort_rd1", rd[1], 64'hB0B0_0000_0000_0001);
        chk("abort_rd2", rd[2], 64'hA0A0_0000_0000_0002);
        chk("abort_rd3", rd[3], 64'hA0A0_0000_0000_0003);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
